// File: rtl/uart_pkg.sv
// uart_pkg
//   Constants shared by the UART command decoder and the status transmitter:
//   ASCII characters used in the status line, message length, FSM state
//   encoding and mode codes. Also two small helpers that map a mode code to
//   its line prefix and a BCD digit to its ASCII character.
package uart_pkg;

    localparam int MSG_LEN = 15;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_Q     = 8'h3F;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    // Mode codes, identical to the ones the command decoder produces.
    localparam logic [1:0] MODE_SW_A   = 2'b00;
    localparam logic [1:0] MODE_SW_B   = 2'b01;
    localparam logic [1:0] MODE_WATCH  = 2'b10;
    localparam logic [1:0] MODE_UNUSED = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_SEND_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_SEND = ST_SEND_ENC,
        ST_WAIT = ST_WAIT_ENC
    } state_t;

    function automatic logic [7:0] mode_char(input logic [1:0] mode);
        logic [7:0] c;
        case (mode)
            MODE_SW_A, MODE_SW_B: c = CH_S;
            MODE_WATCH:           c = CH_W;
            default:              c = CH_Q;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return CH_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd99.sv
// bin2bcd99
//   Combinational 7-bit binary to two BCD digits. Values above 99 saturate
//   to 9/9 so an out-of-range field still prints as two digits.
// Ports
//   bin   in  7  binary value
//   tens  out 4  tens digit (0..9)
//   ones  out 4  ones digit (0..9)
module bin2bcd99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_comb begin
        tens = 4'd0;
        ones = 4'd0;
        if (bin > 7'd99) begin
            tens = 4'd9;
            ones = 4'd9;
        end else begin
            // Threshold chain instead of a divider: the last threshold met wins.
            for (int k = 1; k < 10; k++) begin
                if (bin >= 7'(10 * k)) begin
                    tens = 4'(k);
                end
            end
            ones = 4'(bin - 7'(tens) * 7'd10);
        end
    end

endmodule

// File: rtl/uart_status_tx.sv
// uart_status_tx
//   Formats the current mode and time as a 15-byte ASCII line
//   ("W 12:05:37.42\r\n") and feeds it byte by byte to a byte-level uart_tx.
//   A report starts on send_req, on the periodic auto tick, or from a pending
//   request that arrived while a report was already running.
// Parameters
//   AUTO_PERIOD  clocks between automatic reports; 0 disables them
// Ports
//   clk       in   1  system clock
//   rst       in   1  synchronous active-high reset
//   send_req  in   1  one-cycle request for one report
//   mode      in   2  00/01 stopwatch, 10 watch, 11 unused
//   hour      in   5  hours, binary
//   min       in   6  minutes, binary
//   sec       in   6  seconds, binary
//   csec      in   7  centiseconds, binary
//   tx_busy   in   1  uart_tx is shifting a byte
//   tx_done   in   1  uart_tx finished the byte (pulse)
//   tx_data   out  8  byte to send, held until the next byte
//   tx_start  out  1  one-cycle launch pulse for tx_data
//   busy      out  1  report in progress
module uart_status_tx
    import uart_pkg::*;
#(
    parameter int AUTO_PERIOD = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [1:0] mode,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] csec,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy
);

    // A zero period would give a zero-width counter; keep one bit in that case.
    localparam int W = (AUTO_PERIOD > 0) ? $clog2(AUTO_PERIOD + 1) : 1;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    state_t     state_reg;
    logic [3:0] index_reg;
    logic       pending_reg;
    logic [7:0] tx_data_reg;
    logic       tx_start_reg;
    logic [1:0] snap_mode_reg;
    // Snapshot fields: 0 hour, 1 min, 2 sec, 3 csec.
    logic [6:0] snap_field_reg [4];
    logic [3:0] tens [4];
    logic [3:0] ones [4];
    logic       auto_tick;
    logic       request;
    logic [7:0] byte_next;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            bin2bcd99 u_bcd (
                .bin  (snap_field_reg[gi]),
                .tens (tens[gi]),
                .ones (ones[gi])
            );
        end
    endgenerate

    // Free-running report timer; never paused while a report is busy.
    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            logic [W-1:0] auto_cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    auto_cnt_reg <= '0;
                end else if (auto_cnt_reg == W'(AUTO_PERIOD - 1)) begin
                    auto_cnt_reg <= '0;
                end else begin
                    auto_cnt_reg <= auto_cnt_reg + W'(1);
                end
            end
            assign auto_tick = (auto_cnt_reg == W'(AUTO_PERIOD - 1));
        end else begin : g_no_auto
            assign auto_tick = 1'b0;
        end
    endgenerate

    assign request = send_req | auto_tick;

    always_comb begin
        byte_next = CH_LF;
        case (index_reg)
            4'd0:  byte_next = mode_char(snap_mode_reg);
            4'd1:  byte_next = CH_SPACE;
            4'd2:  byte_next = digit_char(tens[0]);
            4'd3:  byte_next = digit_char(ones[0]);
            4'd4:  byte_next = CH_COLON;
            4'd5:  byte_next = digit_char(tens[1]);
            4'd6:  byte_next = digit_char(ones[1]);
            4'd7:  byte_next = CH_COLON;
            4'd8:  byte_next = digit_char(tens[2]);
            4'd9:  byte_next = digit_char(ones[2]);
            4'd10: byte_next = CH_DOT;
            4'd11: byte_next = digit_char(tens[3]);
            4'd12: byte_next = digit_char(ones[3]);
            4'd13: byte_next = CH_CR;
            default: byte_next = CH_LF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            index_reg     <= 4'd0;
            pending_reg   <= 1'b0;
            tx_data_reg   <= 8'h00;
            tx_start_reg  <= 1'b0;
            snap_mode_reg <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                snap_field_reg[i] <= 7'd0;
            end
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (request || pending_reg) begin
                        // Snapshot taken once per report so the line is self-consistent.
                        snap_mode_reg     <= mode;
                        snap_field_reg[0] <= {2'b00, hour};
                        snap_field_reg[1] <= {1'b0, min};
                        snap_field_reg[2] <= {1'b0, sec};
                        snap_field_reg[3] <= csec;
                        pending_reg       <= 1'b0;
                        index_reg         <= 4'd0;
                        state_reg         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (request) begin
                        pending_reg <= 1'b1;
                    end
                    if (!tx_busy) begin
                        tx_data_reg  <= byte_next;
                        tx_start_reg <= 1'b1;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Also covers a request arriving with the final tx_done.
                    if (request) begin
                        pending_reg <= 1'b1;
                    end
                    if (tx_done) begin
                        if (index_reg == LAST_IDX) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            index_reg <= index_reg + 4'd1;
                            state_reg <= ST_SEND;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule
